// File: rtl/horn_friends_enum_if.sv
// Fact-load, query and solution-stream signals of the horn_friends_enum solver.
// The master side is the host; the slave side is the solver.
interface horn_friends_enum_if #(
    parameter int ATOM_W    = 3,
    parameter int NUM_FACTS = 4
);
    localparam int IDX_W = (NUM_FACTS > 1) ? $clog2(NUM_FACTS) : 1;

    logic              fact_we;
    logic [IDX_W-1:0]  fact_idx;
    logic              fact_en;
    logic [ATOM_W-1:0] fact_a;
    logic [ATOM_W-1:0] fact_b;
    logic              q_valid;
    logic              q_ready;
    logic              q_mode;
    logic [ATOM_W-1:0] q_a;
    logic [ATOM_W-1:0] q_b;
    logic              s_valid;
    logic              s_ready;
    logic              s_hit;
    logic [ATOM_W-1:0] s_b;
    logic [ATOM_W-1:0] s_c;
    logic              s_last;
    logic              busy;

    modport master (
        output fact_we, fact_idx, fact_en, fact_a, fact_b,
        output q_valid, q_mode, q_a, q_b, s_ready,
        input  q_ready, s_valid, s_hit, s_b, s_c, s_last, busy
    );

    modport slave (
        input  fact_we, fact_idx, fact_en, fact_a, fact_b,
        input  q_valid, q_mode, q_a, q_b, s_ready,
        output q_ready, s_valid, s_hit, s_b, s_c, s_last, busy
    );
endinterface

// File: rtl/horn_friends_enum.sv
// Clocked solver for friends(A,B) :- enemies(A,C), enemies(C,B), A != B over a
// loadable hates/2 table; searches C (and B in ENUM mode) one pair per cycle.
module horn_friends_enum #(
    parameter int ATOM_W    = 3,
    parameter int NUM_ATOMS = 6,
    parameter int NUM_FACTS = 4
) (
    input logic                clk,
    input logic                rst,
    horn_friends_enum_if.slave bus
);
    localparam int IDX_W = (NUM_FACTS > 1) ? $clog2(NUM_FACTS) : 1;
    localparam logic [ATOM_W-1:0] LAST_ATOM = ATOM_W'(NUM_ATOMS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    state_t                           state_r, state_s;
    logic [NUM_FACTS-1:0]             fen_r;
    logic [NUM_FACTS-1:0][ATOM_W-1:0] fa_r, fb_r;
    logic [IDX_W-1:0]                 widx_s;
    logic [ATOM_W-1:0]                a_r, a_s, b_r, b_s, c_r, c_s;
    logic                             mode_r, mode_s;
    logic                             s_valid_r, s_valid_s, s_hit_r, s_hit_s;
    logic [ATOM_W-1:0]                s_b_r, s_b_s, s_c_r, s_c_s;
    logic                             s_last_r, s_last_s;
    logic                             q_ready_r, q_ready_s, busy_r, busy_s;
    logic                             pair_hit_s;

    // Symmetric closure of hates/2 over every enabled slot.
    function automatic logic enemies_f(
        input logic [ATOM_W-1:0]                x,
        input logic [ATOM_W-1:0]                y,
        input logic [NUM_FACTS-1:0]             en,
        input logic [NUM_FACTS-1:0][ATOM_W-1:0] fa,
        input logic [NUM_FACTS-1:0][ATOM_W-1:0] fb
    );
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FACTS; i++) begin
            if (en[i] && (((fa[i] == x) && (fb[i] == y)) || ((fa[i] == y) && (fb[i] == x)))) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    assign widx_s     = bus.fact_idx;
    assign pair_hit_s = enemies_f(a_r, c_r, fen_r, fa_r, fb_r) &
                        enemies_f(c_r, b_r, fen_r, fa_r, fb_r) & (a_r != b_r);

    // Fact table: writable only while idle, so a running query sees a frozen table.
    always_ff @(posedge clk) begin
        if (rst) begin
            fen_r <= '0;
            fa_r  <= '0;
            fb_r  <= '0;
        end else if (bus.fact_we && (state_r == ST_IDLE) && (int'(widx_s) < NUM_FACTS)) begin
            fen_r[widx_s] <= bus.fact_en;
            fa_r[widx_s]  <= bus.fact_a;
            fb_r[widx_s]  <= bus.fact_b;
        end
    end

    // Next-state, search counters and next values of the registered outputs.
    always_comb begin
        state_s  = state_r;
        a_s      = a_r;
        b_s      = b_r;
        c_s      = c_r;
        mode_s   = mode_r;
        s_hit_s  = s_hit_r;
        s_b_s    = s_b_r;
        s_c_s    = s_c_r;
        s_last_s = s_last_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.q_valid) begin
                    a_s     = bus.q_a;
                    mode_s  = bus.q_mode;
                    b_s     = bus.q_mode ? '0 : bus.q_b;
                    c_s     = '0;
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (pair_hit_s) begin
                    s_hit_s  = 1'b1;
                    s_b_s    = b_r;
                    s_c_s    = c_r;
                    s_last_s = ~mode_r;
                    state_s  = ST_EMIT;
                end else if (c_r < LAST_ATOM) begin
                    c_s = c_r + 1'b1;
                end else if (!mode_r) begin
                    s_hit_s  = 1'b0;
                    s_b_s    = b_r;
                    s_c_s    = '0;
                    s_last_s = 1'b1;
                    state_s  = ST_EMIT;
                end else if (b_r < LAST_ATOM) begin
                    b_s = b_r + 1'b1;
                    c_s = '0;
                end else begin
                    s_hit_s  = 1'b0;
                    s_b_s    = '0;
                    s_c_s    = '0;
                    s_last_s = 1'b1;
                    state_s  = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (bus.s_ready) begin
                    if (s_last_r) begin
                        state_s = ST_IDLE;
                    end else if (b_r < LAST_ATOM) begin
                        b_s     = b_r + 1'b1;
                        c_s     = '0;
                        state_s = ST_SCAN;
                    end else begin
                        // Hit on the highest B: only the terminator remains.
                        s_hit_s  = 1'b0;
                        s_b_s    = '0;
                        s_c_s    = '0;
                        s_last_s = 1'b1;
                        state_s  = ST_EMIT;
                    end
                end else begin
                    state_s = ST_EMIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        s_valid_s = (state_s == ST_EMIT);
        q_ready_s = (state_s == ST_IDLE);
        busy_s    = (state_s != ST_IDLE);
    end

    // State, search registers and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            a_r       <= '0;
            b_r       <= '0;
            c_r       <= '0;
            mode_r    <= 1'b0;
            s_valid_r <= 1'b0;
            s_hit_r   <= 1'b0;
            s_b_r     <= '0;
            s_c_r     <= '0;
            s_last_r  <= 1'b0;
            q_ready_r <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            a_r       <= a_s;
            b_r       <= b_s;
            c_r       <= c_s;
            mode_r    <= mode_s;
            s_valid_r <= s_valid_s;
            s_hit_r   <= s_hit_s;
            s_b_r     <= s_b_s;
            s_c_r     <= s_c_s;
            s_last_r  <= s_last_s;
            q_ready_r <= q_ready_s;
            busy_r    <= busy_s;
        end
    end

    assign bus.q_ready = q_ready_r;
    assign bus.s_valid = s_valid_r;
    assign bus.s_hit   = s_hit_r;
    assign bus.s_b     = s_b_r;
    assign bus.s_c     = s_c_r;
    assign bus.s_last  = s_last_r;
    assign bus.busy    = busy_r;
endmodule

// File: doc/horn_friends_enum.md
Name: horn_friends_enum

Overview:
- Sequential, parametrised successor to the combinational predicate circuits produced by the Prolog-to-Verilog flow.
- Holds a loadable `hates/2` fact table and evaluates `friends(A,B) :- enemies(A,C), enemies(C,B), A != B`, where `enemies(X,Y) = hates(X,Y) | hates(Y,X)`.
- Searches the existential variable C, and in enumerate mode also B, by clocked iteration instead of relying on an annealer.
- Returns solutions with witnesses as a valid/ready stream. Used as a classical reference solver for checking annealer results.

Parameters:
- ATOM_W, 3, bit width of an atom code.
- NUM_ATOMS, 6, number of atom codes scanned (0..NUM_ATOMS-1); must satisfy NUM_ATOMS <= 2**ATOM_W.
- NUM_FACTS, 4, number of `hates/2` fact slots; IDX_W = max(1, $clog2(NUM_FACTS)).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- fact_we  in  1  fact write strobe
- fact_idx  in  IDX_W  slot to write
- fact_en  in  1  slot enable bit to write (0 deletes the fact)
- fact_a  in  ATOM_W  first argument of the hates fact
- fact_b  in  ATOM_W  second argument of the hates fact
- q_valid  in  1  query request
- q_ready  out  1  query accepted when q_valid & q_ready
- q_mode  in  1  0 = CHECK (A, B bound), 1 = ENUM (A bound, B free)
- q_a  in  ATOM_W  bound A
- q_b  in  ATOM_W  bound B; ignored in ENUM
- s_valid  out  1  response beat valid
- s_ready  in  1  response beat consumed when s_valid & s_ready
- s_hit  out  1  1 = solution beat; 0 = no-solution/terminator beat
- s_b  out  ATOM_W  B of the solution
- s_c  out  ATOM_W  witness C of the solution
- s_last  out  1  final beat of the current query
- busy  out  1  high from query acceptance until the last beat is consumed

Behaviour:
- Reset (synchronous, priority over all inputs):
  - All fact_en bits cleared; state IDLE.
  - q_ready=1, s_valid=0, s_hit=0, s_b=0, s_c=0, s_last=0, busy=0.
  - Reset mid-scan or mid-emit aborts the query with no further beats.
- Fact table:
  - Registered. A write with fact_we=1 in IDLE takes effect the next cycle.
  - fact_we while busy is ignored, so the table is stable during a query.
  - A fact_we in the same cycle as query acceptance is applied first.
- Pair predicate P(b,c), combinational over all enabled slots:
  - P(b,c) = enemies(q_a,c) & enemies(c,b) & (q_a != b), using A latched at acceptance.
- States:
  - IDLE: q_ready=1. On q_valid, latch A, mode and B (CHECK: B=q_b; ENUM: B=0); set C=0 → SCAN.
  - SCAN: q_ready=0; evaluates one (B,C) pair per cycle.
    - If P true: load s_b=B, s_c=C, s_hit=1; s_last=1 in CHECK, 0 in ENUM → EMIT.
    - Else if C < NUM_ATOMS-1: C++.
    - Else, CHECK: load terminator (s_hit=0, s_b=B, s_c=0, s_last=1) → EMIT.
    - Else, ENUM with B < NUM_ATOMS-1: B++, C=0.
    - Else, ENUM with B = NUM_ATOMS-1: load terminator (s_b=0, s_c=0) → EMIT.
  - EMIT: s_valid=1; outputs held stable until s_ready.
    - On handshake of an s_last beat → IDLE (s_valid=0, busy=0).
    - On handshake of an ENUM hit: if B < NUM_ATOMS-1, B++, C=0 → SCAN; else load terminator and remain in EMIT.
- Search rules:
  - Only the first (lowest) witness C per B is reported. No duplicate B beats.
  - B is reported in ascending order.
- Response shape:
  - CHECK returns exactly one beat.
  - ENUM returns zero or more hit beats followed by one terminator beat (s_hit=0, s_last=1).
- Latency (accept at cycle t, s_ready held high):
  - CHECK hit with witness C=k: s_valid at t+2+k.
  - CHECK miss: s_valid at t+1+NUM_ATOMS.
  - ENUM, no hits: terminator at t+1+NUM_ATOMS².
- Atom codes >= NUM_ATOMS are never scanned as B or C. They may still appear as A, or as q_b in CHECK mode.
- Fact slots with identical contents are harmless (OR semantics).

Test Plan:
- Atoms alice=0, bob=1, charlie=2. Load slot0=(0,1,en), slot1=(1,2,en). CHECK A=0, B=2, accept at t → at t+3: s_valid, s_hit=1, s_c=1, s_last=1.
- Same facts, CHECK A=0, B=0 → single beat at t+7: s_hit=0, s_last=1 (A != B rule).
- Same facts, ENUM A=0 → beat {hit=1, b=2, c=1, last=0}, then beat {hit=0, last=1}. ENUM A=1 → terminator only, at t+37. ENUM A=2 → {hit=1, b=0, c=1}, then terminator.
- ENUM A=0 with s_ready low for 5 cycles after the first s_valid → s_b, s_c, s_hit held stable. No beat lost or duplicated after s_ready rises.
- fact_we slot1=(1,2,dis) issued while busy → ignored; the query still finds c=1. The same write in IDLE, then CHECK 0,2 → miss.
- rst asserted during SCAN of an ENUM → next cycle s_valid=0, q_ready=1, busy=0, all facts cleared. A following CHECK 0,2 → miss.
